// File: rtl/usb_rx_pkg.sv
// Shared types and line constants for the USB RX bit decoder.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SE0A = 2'd1,
        SE0B = 2'd2,
        IDLE = 2'd3
    } rx_dec_state_t;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decode against the previous line level plus the consecutive-ones counter
// that marks the bit following ONES_LIMIT ones as stuffing.
module usb_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int ONES_LIMIT = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic dec_en,
    input  logic line_upd,
    input  logic d_plus,
    output logic keep,
    output logic dbit,
    output logic stuff_err
);

    localparam int OW = $clog2(ONES_LIMIT + 1);

    logic          prev_line_q, prev_line_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic          at_limit;

    always_comb begin
        dbit       = (d_plus == prev_line_q);
        at_limit   = (ones_cnt_q == OW'(ONES_LIMIT));
        keep       = dec_en && !at_limit;
        stuff_err  = dec_en && at_limit && dbit;
        prev_line_d = prev_line_q;
        ones_cnt_d  = ones_cnt_q;
        if (clear) begin
            // the last SYNC bit leaves the line in K
            prev_line_d = LINE_K;
            ones_cnt_d  = '0;
        end else begin
            if (line_upd) begin
                prev_line_d = d_plus;
            end
            if (dec_en) begin
                if (at_limit || !dbit) begin
                    ones_cnt_d = '0;
                end else begin
                    ones_cnt_d = ones_cnt_q + OW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_line_q <= LINE_J;
            ones_cnt_q  <= '0;
        end else begin
            prev_line_q <= prev_line_d;
            ones_cnt_q  <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB RX bit decoder: NRZI/unstuff, SE0-SE0-J end-of-packet detection and
// LSB-first byte assembly, with registered one-cycle output strobes.
//   state | meaning
//   RUN   | decoding data bits
//   SE0A  | one SE0 seen; a non-SE0 next is a glitch and decodes normally
//   SE0B  | two or more SE0 seen; J completes EOP, anything else aborts
//   IDLE  | packet over, samples ignored until rx_clear
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int ONES_LIMIT = 6,
    parameter int BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_plus,
    input  logic              d_minus,
    input  logic              sample,
    input  logic              rx_clear,
    output logic              rx_bit,
    output logic              bit_strobe,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              eop,
    output logic              stuff_error,
    output logic              partial_byte
);

    localparam int BW = $clog2(BYTE_W);

    rx_dec_state_t     state_q, state_d;
    logic              armed_q, armed_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d, shreg_next;
    logic              rx_bit_q, rx_bit_d;
    logic              bit_strobe_q, bit_strobe_d;
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              eop_q, eop_d;
    logic              stuff_error_q, stuff_error_d;
    logic              partial_byte_q, partial_byte_d;

    logic se0, line_j, smp;
    logic dec_en, line_upd, eop_hit;
    logic keep, dbit, stuff_err;

    // after async reset nothing decodes until a packet start re-arms the path
    assign se0    = !d_plus && !d_minus;
    assign line_j = (d_plus == LINE_J) && (d_minus == LINE_K);
    assign smp    = sample && armed_q && !rx_clear;

    usb_nrzi_unstuff #(
        .ONES_LIMIT(ONES_LIMIT)
    ) u_nrzi (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (rx_clear),
        .dec_en    (dec_en),
        .line_upd  (line_upd),
        .d_plus    (d_plus),
        .keep      (keep),
        .dbit      (dbit),
        .stuff_err (stuff_err)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_clear) begin
            state_d = RUN;
        end else if (smp) begin
            case (state_q)
                RUN:     if (se0) state_d = SE0A;
                SE0A:    state_d = se0 ? SE0B : RUN;
                SE0B:    if (!se0) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        dec_en   = smp && !se0 && ((state_q == RUN) || (state_q == SE0A));
        line_upd = smp && !se0 && (state_q != IDLE);
        eop_hit  = smp && (state_q == SE0B) && line_j;
    end

    always_comb begin
        armed_d        = armed_q || rx_clear;
        bit_cnt_d      = bit_cnt_q;
        shreg_next     = {dbit, shreg_q[BYTE_W-1:1]};
        shreg_d        = shreg_q;
        rx_bit_d       = rx_bit_q;
        bit_strobe_d   = 1'b0;
        rx_byte_d      = rx_byte_q;
        byte_valid_d   = 1'b0;
        eop_d          = 1'b0;
        stuff_error_d  = stuff_error_q;
        partial_byte_d = partial_byte_q;
        if (rx_clear) begin
            bit_cnt_d      = '0;
            shreg_d        = '0;
            stuff_error_d  = 1'b0;
            partial_byte_d = 1'b0;
        end else begin
            if (keep) begin
                rx_bit_d     = dbit;
                bit_strobe_d = 1'b1;
                shreg_d      = shreg_next;
                if (bit_cnt_q == BW'(BYTE_W - 1)) begin
                    bit_cnt_d    = '0;
                    rx_byte_d    = shreg_next;
                    byte_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            if (stuff_err) begin
                stuff_error_d = 1'b1;
            end
            if (eop_hit) begin
                eop_d          = 1'b1;
                partial_byte_d = (bit_cnt_q != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            armed_q        <= 1'b0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            rx_bit_q       <= 1'b0;
            bit_strobe_q   <= 1'b0;
            rx_byte_q      <= '0;
            byte_valid_q   <= 1'b0;
            eop_q          <= 1'b0;
            stuff_error_q  <= 1'b0;
            partial_byte_q <= 1'b0;
        end else begin
            armed_q        <= armed_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            rx_bit_q       <= rx_bit_d;
            bit_strobe_q   <= bit_strobe_d;
            rx_byte_q      <= rx_byte_d;
            byte_valid_q   <= byte_valid_d;
            eop_q          <= eop_d;
            stuff_error_q  <= stuff_error_d;
            partial_byte_q <= partial_byte_d;
        end
    end

    assign rx_bit       = rx_bit_q;
    assign bit_strobe   = bit_strobe_q;
    assign rx_byte      = rx_byte_q;
    assign byte_valid   = byte_valid_q;
    assign eop          = eop_q;
    assign stuff_error  = stuff_error_q;
    assign partial_byte = partial_byte_q;

endmodule
